// File: rtl/npu_dma_axi_engine.sv
// Store-and-forward DMA copy engine: splits a (src, dst, bytes) request into
// 4 KiB-safe AXI4 read bursts, buffers each burst, then writes it back out.
module npu_dma_axi_engine #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 256,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dma_req_valid,
  output logic                dma_req_ready,
  input  logic [ADDR_W-1:0]   dma_req_src,
  input  logic [ADDR_W-1:0]   dma_req_dst,
  input  logic [31:0]         dma_req_bytes,
  output logic                dma_resp_done,
  output logic                busy,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rlast,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int BUF_AW     = (MAX_BURST_BEATS > 1) ? $clog2(MAX_BURST_BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [27:0]       remaining_q;   // one extra bit so a 4 GiB-ish length cannot wrap to 0
  logic [8:0]        burst_q, idx_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [7:0]        arlen_q, awlen_q;
  logic [DATA_W-1:0] buf_q [MAX_BURST_BEATS];

  logic [27:0]       req_beats, burst_calc;
  logic [12:0]       src_room, dst_room;
  logic              beat_last;
  logic              unused_bits;

  assign req_beats = 28'((33'(dma_req_bytes) + 33'(BEAT_BYTES - 1)) >> BEAT_SH);
  assign src_room  = (13'd4096 - {1'b0, src_q[11:0]}) >> BEAT_SH;
  assign dst_room  = (13'd4096 - {1'b0, dst_q[11:0]}) >> BEAT_SH;
  assign beat_last = (idx_q == burst_q - 9'd1);

  always_comb begin
    burst_calc = (remaining_q < 28'(MAX_BURST_BEATS)) ? remaining_q : 28'(MAX_BURST_BEATS);
    if ({15'd0, src_room} < burst_calc) burst_calc = {15'd0, src_room};
    if ({15'd0, dst_room} < burst_calc) burst_calc = {15'd0, dst_room};
  end

  // rlast is deliberately ignored: the beat counter decides where a burst ends
  assign unused_bits = ^{m_axi_rlast, burst_calc[27:9]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (dma_req_valid) state_nxt = (dma_req_bytes == 32'd0) ? S_DONE : S_CALC;
      S_CALC: state_nxt = S_AR;
      S_AR:   if (m_axi_arready) state_nxt = S_R;
      S_R:    if (m_axi_rvalid && beat_last) state_nxt = S_AW;
      S_AW:   if (m_axi_awready) state_nxt = S_W;
      S_W:    if (m_axi_wready && beat_last) state_nxt = S_B;
      S_B:    if (m_axi_bvalid) state_nxt = (remaining_q == 28'(burst_q)) ? S_DONE : S_CALC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      idx_q       <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (dma_req_valid) begin
          src_q       <= dma_req_src & ~ADDR_W'(BEAT_BYTES - 1);
          dst_q       <= dma_req_dst & ~ADDR_W'(BEAT_BYTES - 1);
          remaining_q <= req_beats;
        end
        S_CALC: begin
          burst_q  <= burst_calc[8:0];
          araddr_q <= src_q;
          arlen_q  <= burst_calc[7:0] - 8'd1;
          idx_q    <= '0;
        end
        S_R: if (m_axi_rvalid) begin
          idx_q <= beat_last ? 9'd0 : idx_q + 9'd1;
          if (beat_last) begin
            awaddr_q <= dst_q;
            awlen_q  <= arlen_q;
          end
        end
        S_W: if (m_axi_wready) idx_q <= idx_q + 9'd1;
        S_B: if (m_axi_bvalid) begin
          src_q       <= src_q + (ADDR_W'(burst_q) << BEAT_SH);
          dst_q       <= dst_q + (ADDR_W'(burst_q) << BEAT_SH);
          remaining_q <= remaining_q - 28'(burst_q);
        end
        default: ;
      endcase
    end
  end

  // Beat buffer contents are don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (state == S_R && m_axi_rvalid) buf_q[idx_q[BUF_AW-1:0]] <= m_axi_rdata;
  end

  assign dma_req_ready = (state == S_IDLE);
  assign dma_resp_done = (state == S_DONE);
  assign busy          = (state != S_IDLE) && (state != S_DONE);

  assign m_axi_arvalid = (state == S_AR);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(BEAT_SH);
  assign m_axi_rready  = (state == S_R);

  assign m_axi_awvalid = (state == S_AW);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BEAT_SH);

  assign m_axi_wvalid  = (state == S_W);
  assign m_axi_wdata   = buf_q[idx_q[BUF_AW-1:0]];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == S_W) && beat_last;
  assign m_axi_bready  = (state == S_B);

endmodule
